// File: rtl/scope_trace_render.sv
// scope_trace_render: triggered multi-channel trace capture into a
// double buffer, composited over a video overlay with 2-cycle latency.
module scope_trace_render #(
  parameter int N_CH     = 2,
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 480,
  parameter int X_OFF    = 160,
  parameter int AUTO_TO  = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [N_CH*SAMPLE_W-1:0] sample,
  input  logic [7:0]               decim,
  input  logic [1:0]               trig_ch,
  input  logic [SAMPLE_W-1:0]      trig_level,
  input  logic [1:0]               trig_mode,
  input  logic                     rearm,
  input  logic                     frame_start,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic                     video_on,
  input  logic [8:0]               bg_rgb,
  output logic [8:0]               rgb,
  output logic [1:0]               state,
  output logic                     triggered
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = $clog2(AUTO_TO + 1);
  localparam int VW = N_CH * 9;

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [AW-1:0] ALIM = AW'(AUTO_TO - 1);

  localparam logic [1:0] M_AUTO   = 2'd0;
  localparam logic [1:0] M_SINGLE = 2'd2;
  localparam logic [1:0] M_FREE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } st_e;

  function automatic logic [8:0] ycode(
    input logic [8:0] t
  );
    return (t > 9'd479) ? 9'd0 : 9'd479 - t;
  endfunction

  function automatic logic [8:0] colour(
    input int k
  );
    unique case (k)
      0:       colour = 9'b000111000;
      1:       colour = 9'b111111000;
      2:       colour = 9'b000111111;
      default: colour = 9'b111000111;
    endcase
  endfunction

  // Two trace banks; sel_q picks the one on screen.
  logic [VW-1:0] mem_q [2][DEPTH];

  st_e                 state_q;
  logic [1:0]          mode_q;
  logic [7:0]          dec_q;
  logic [CW-1:0]       col_q;
  logic [AW-1:0]       auto_q;
  logic [SAMPLE_W-1:0] prev_q;
  logic                real_q;
  logic                trig_q;
  logic                sel_q;
  logic                shown_q;

  logic [SAMPLE_W-1:0] cur;
  logic [VW-1:0]       wr_v;
  logic [1:0]          mode_e;
  logic                accept;
  logic                edge_hit;
  logic                force_hit;
  logic                fire;
  logic                we;
  logic [CW-1:0]       waddr;
  logic                swap;

  // Trigger source mux and per-channel screen codes for a sample set.
  always_comb begin
    cur  = sample[SAMPLE_W-1:0];
    wr_v = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (trig_ch == 2'(k))
        cur = sample[k*SAMPLE_W +: SAMPLE_W];
      wr_v[k*9 +: 9] =
        ycode(sample[k*SAMPLE_W + SAMPLE_W - 9 +: 9]);
    end
  end

  // Mode changes are only honoured while not mid-capture.
  assign mode_e = (state_q == IDLE || state_q == WAIT_TRIG)
                ? trig_mode : mode_q;

  assign accept = sample_valid && (state_q != DONE)
               && (dec_q == decim);

  assign edge_hit  = (prev_q < trig_level)
                  && (cur >= trig_level);
  assign force_hit = (mode_e == M_AUTO) && (auto_q == ALIM);

  assign fire = accept && (state_q == WAIT_TRIG)
             && ((mode_e == M_FREE) || edge_hit || force_hit);

  assign we    = fire || (accept && state_q == CAPTURE);
  assign waddr = fire ? '0 : col_q;
  assign swap  = (state_q == DONE) && frame_start;

  // Capture FSM, decimation, auto-timeout and trigger history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= M_AUTO;
      dec_q   <= '0;
      col_q   <= '0;
      auto_q  <= '0;
      prev_q  <= '0;
      real_q  <= 1'b0;
      trig_q  <= 1'b0;
      shown_q <= 1'b0;
    end else begin
      if (state_q == IDLE || state_q == WAIT_TRIG)
        mode_q <= trig_mode;
      if (sample_valid && state_q != DONE)
        dec_q <= (dec_q == decim) ? 8'd0 : dec_q + 8'd1;
      if (accept)
        prev_q <= cur;
      unique case (state_q)
        IDLE: begin
          if (mode_e != M_SINGLE || rearm) begin
            state_q <= WAIT_TRIG;
            auto_q  <= '0;
            col_q   <= '0;
          end
        end
        WAIT_TRIG: begin
          if (fire) begin
            real_q <= edge_hit && (mode_e != M_FREE);
            if (LAST == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= CAPTURE;
              col_q   <= CW'(1);
            end
          end else if (accept && auto_q != ALIM) begin
            auto_q <= auto_q + AW'(1);
          end
        end
        CAPTURE: begin
          if (accept) begin
            if (col_q == LAST)
              state_q <= DONE;
            else
              col_q <= col_q + CW'(1);
          end
        end
        DONE: begin
          if (frame_start) begin
            trig_q  <= real_q;
            shown_q <= 1'b1;
            auto_q  <= '0;
            col_q   <= '0;
            state_q <= (mode_q == M_SINGLE)
                     ? IDLE : WAIT_TRIG;
          end
        end
      endcase
    end
  end

  // Bank select survives reset so an abandoned capture never swaps.
  always_ff @(posedge clk) begin
    if (!reset && swap)
      sel_q <= ~sel_q;
  end

  // Column write into the bank that is not on screen.
  always_ff @(posedge clk) begin
    if (!reset && we)
      mem_q[~sel_q][waddr] <= wr_v;
  end

  logic [9:0]    x_q;
  logic [9:0]    y_q;
  logic          von_q;
  logic [8:0]    bg_q;
  logic [8:0]    rgb_q;
  logic [10:0]   c11;
  logic          inr;
  logic [CW-1:0] ci;
  logic [CW-1:0] cp;
  logic [VW-1:0] cur_v;
  logic [VW-1:0] prv_v;
  logic [8:0]    a_v;
  logic [8:0]    b_v;
  logic [8:0]    lo_v;
  logic [8:0]    hi_v;
  logic [8:0]    pix_d;

  // First pixel stage: register the raster inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      von_q <= 1'b0;
      bg_q  <= '0;
    end else begin
      x_q   <= x;
      y_q   <= y;
      von_q <= video_on;
      bg_q  <= bg_rgb;
    end
  end

  assign c11 = {1'b0, x_q} - 11'(X_OFF);
  assign inr = ({1'b0, x_q} >= 11'(X_OFF))
            && (c11 < 11'(DEPTH));
  assign ci  = inr ? c11[CW-1:0] : '0;
  assign cp  = (ci == '0) ? ci : ci - CW'(1);

  // Before the first swap the screen shows a flat bottom line.
  assign cur_v = shown_q ? mem_q[sel_q][ci]
                         : {N_CH{9'd479}};
  assign prv_v = shown_q ? mem_q[sel_q][cp]
                         : {N_CH{9'd479}};

  // Vertical-fill hit test; lowest channel is applied last and wins.
  always_comb begin
    pix_d = bg_q;
    a_v   = '0;
    b_v   = '0;
    lo_v  = '0;
    hi_v  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      a_v  = cur_v[k*9 +: 9];
      b_v  = prv_v[k*9 +: 9];
      lo_v = (a_v < b_v) ? a_v : b_v;
      hi_v = (a_v < b_v) ? b_v : a_v;
      if (inr && (y_q >= {1'b0, lo_v})
              && (y_q <= {1'b0, hi_v}))
        pix_d = colour(k);
    end
    if (!von_q)
      pix_d = '0;
  end

  // Second pixel stage: registered colour output.
  always_ff @(posedge clk) begin
    if (reset)
      rgb_q <= '0;
    else
      rgb_q <= pix_d;
  end

  assign rgb       = rgb_q;
  assign state     = state_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_scope_trace_render.sv
// tb_scope_trace_render: directed capture scenarios with a queued
// pixel scoreboard checked by an independent monitor.
module tb_scope_trace_render;

  localparam logic [8:0] BG  = 9'b000000101;
  localparam logic [8:0] GRN = 9'b000111000;
  localparam logic [8:0] YEL = 9'b111111000;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [23:0] sample = '0;
  logic [7:0]  decim = '0;
  logic [1:0]  trig_ch = '0;
  logic [11:0] trig_level = 12'd2048;
  logic [1:0]  trig_mode = 2'd1;
  logic        rearm = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        video_on = 1'b0;
  logic [8:0]  bg_rgb = '0;
  logic [8:0]  rgb;
  logic [1:0]  state;
  logic        triggered;

  int n_cmp = 0;
  int n_bad = 0;

  scope_trace_render #(
    .N_CH(2), .SAMPLE_W(12), .DEPTH(480),
    .X_OFF(160), .AUTO_TO(4096)
  ) dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample(sample),
    .decim(decim), .trig_ch(trig_ch),
    .trig_level(trig_level), .trig_mode(trig_mode),
    .rearm(rearm), .frame_start(frame_start),
    .x(x), .y(y), .video_on(video_on),
    .bg_rgb(bg_rgb), .rgb(rgb),
    .state(state), .triggered(triggered)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] want;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic probe = 1'b0;
  logic p1 = 1'b0;
  logic p2 = 1'b0;

  always @(posedge clk) begin
    p1 <= probe;
    p2 <= p1;
  end

  always @(negedge clk) begin
    if (p2) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL pix_unexpected rgb=%b", rgb);
      end else begin
        mon_e = sbq.pop_front();
        if (rgb !== mon_e.want) begin
          n_bad++;
          $display("FAIL %s rgb=%b want=%b",
                   mon_e.nm, rgb, mon_e.want);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [8:0] got,
                     input logic [8:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic pix(input logic [9:0] px,
                     input logic [9:0] py,
                     input logic vo,
                     input logic [8:0] want,
                     input string nm);
    exp_t e;
    @(posedge clk); #1;
    x = px;
    y = py;
    video_on = vo;
    bg_rgb = BG;
    probe = 1'b1;
    e.want = want;
    e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic pix_done();
    @(posedge clk); #1;
    probe = 1'b0;
    video_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [11:0] c0,
                      input logic [11:0] c1);
    @(posedge clk); #1;
    sample = {c1, c0};
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_rearm();
    @(posedge clk); #1;
    rearm = 1'b1;
    @(posedge clk); #1;
    rearm = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] v;

    // Reset state and flat pre-swap display.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 9'(state), 9'(S_IDLE));
    chk("rst_trig", 9'(triggered), 9'd0);
    chk("rst_rgb", rgb, 9'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_to_wait", 9'(state), 9'(S_WAIT));
    pix(10'd200, 10'd479, 1'b1, GRN, "flat479");
    pix(10'd200, 10'd478, 1'b1, BG, "flat478");
    pix_done();

    // Normal-mode ramp, rising edge at 2048.
    for (int i = 0; i <= 735; i++) begin
      v = (i * 8 > 4095) ? 12'd4095 : 12'(i * 8);
      samp(v, 12'd0);
      if (i == 255) chk("pre_trig", 9'(state), 9'(S_WAIT));
      if (i == 256) chk("trig_2048", 9'(state), 9'(S_CAP));
      if (i == 734) chk("cap_479", 9'(state), 9'(S_CAP));
      if (i == 735) chk("done_480", 9'(state), 9'(S_DONE));
    end
    repeat (3) samp(12'd0, 12'd0);
    chk("done_ignore", 9'(state), 9'(S_DONE));
    pix(10'd160, 10'd223, 1'b1, BG, "no_swap_yet");
    pix_done();
    pulse_fs();
    chk("swap_wait", 9'(state), 9'(S_WAIT));
    chk("trig_real", 9'(triggered), 9'd1);
    pix(10'd160, 10'd223, 1'b1, GRN, "ramp_c0");
    pix(10'd160, 10'd222, 1'b1, BG, "ramp_c0_lo");
    pix(10'd161, 10'd222, 1'b1, GRN, "ramp_c1_fill");
    pix(10'd161, 10'd224, 1'b1, BG, "ramp_c1_hi");
    pix(10'd460, 10'd0, 1'b1, GRN, "ramp_clamp");
    pix(10'd460, 10'd1, 1'b1, BG, "ramp_clamp_hi");
    pix(10'd161, 10'd479, 1'b1, YEL, "ramp_ch1");
    pix(10'd159, 10'd479, 1'b1, BG, "x159");
    pix(10'd640, 10'd479, 1'b1, BG, "x640");
    pix(10'd639, 10'd0, 1'b1, GRN, "ramp_c479");
    pix(10'd160, 10'd223, 1'b0, 9'd0, "video_off");
    pix_done();

    // Auto mode, constant 100 on both channels.
    trig_mode = 2'd0;
    for (int i = 1; i <= 4575; i++) begin
      samp(12'd100, 12'd100);
      if (i == 4095) chk("auto_pre", 9'(state), 9'(S_WAIT));
      if (i == 4096) chk("auto_fire", 9'(state), 9'(S_CAP));
      if (i == 4575) chk("auto_done", 9'(state), 9'(S_DONE));
    end
    pix(10'd160, 10'd223, 1'b1, GRN, "hold_old");
    pix_done();
    pulse_fs();
    chk("trig_auto", 9'(triggered), 9'd0);
    chk("auto_wait", 9'(state), 9'(S_WAIT));
    pix(10'd160, 10'd467, 1'b1, GRN, "overlap_c0");
    pix(10'd639, 10'd467, 1'b1, GRN, "overlap_c479");
    pix(10'd300, 10'd466, 1'b1, BG, "auto_below");
    pix_done();

    // Decimation by 4.
    trig_mode = 2'd1;
    decim = 8'd3;
    repeat (8) samp(12'd0, 12'd0);
    repeat (3) samp(12'd3000, 12'd0);
    chk("decim_skip", 9'(state), 9'(S_WAIT));
    samp(12'd3000, 12'd0);
    chk("decim_trig", 9'(state), 9'(S_CAP));
    for (int j = 1; j <= 1916; j++) begin
      samp(12'(j * 8), 12'd0);
      if (j == 1915) chk("decim_1919", 9'(state), 9'(S_CAP));
      if (j == 1916) chk("decim_1920", 9'(state), 9'(S_DONE));
    end
    pulse_fs();
    chk("trig_decim", 9'(triggered), 9'd1);
    pix(10'd162, 10'd471, 1'b1, GRN, "decim_lo");
    pix(10'd162, 10'd475, 1'b1, GRN, "decim_hi");
    pix(10'd162, 10'd470, 1'b1, BG, "decim_below");
    pix(10'd162, 10'd476, 1'b1, BG, "decim_above");
    pix_done();

    // Single mode capture.
    decim = 8'd0;
    trig_mode = 2'd2;
    trig_level = 12'd1000;
    samp(12'd0, 12'd4095);
    for (int c = 0; c < 480; c++) begin
      v = (c == 9) ? 12'd3032 :
          (c == 10) ? 12'd2712 : 12'd1432;
      samp(v, 12'd4095);
      if (c == 0) begin
        chk("single_trig", 9'(state), 9'(S_CAP));
        pulse_rearm();
        chk("rearm_ign", 9'(state), 9'(S_CAP));
      end
    end
    chk("single_done", 9'(state), 9'(S_DONE));
    pulse_fs();
    chk("single_idle", 9'(state), 9'(S_IDLE));
    chk("trig_single", 9'(triggered), 9'd1);
    pix(10'd170, 10'd100, 1'b1, GRN, "fill_top");
    pix(10'd170, 10'd120, 1'b1, GRN, "fill_mid");
    pix(10'd170, 10'd140, 1'b1, GRN, "fill_bot");
    pix(10'd170, 10'd99, 1'b1, BG, "fill_99");
    pix(10'd170, 10'd141, 1'b1, BG, "fill_141");
    pix(10'd170, 10'd120, 1'b0, 9'd0, "fill_off");
    pix(10'd169, 10'd200, 1'b1, GRN, "fill_c9");
    pix_done();
    samp(12'd0, 12'd4095);
    samp(12'd3000, 12'd4095);
    samp(12'd3000, 12'd4095);
    chk("single_hold", 9'(state), 9'(S_IDLE));
    pulse_rearm();
    chk("rearm_go", 9'(state), 9'(S_WAIT));
    samp(12'd0, 12'd4095);
    for (int c = 0; c <= 200; c++)
      samp(12'd1432, 12'd4095);
    chk("cap_c200", 9'(state), 9'(S_CAP));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_cap", 9'(state), 9'(S_IDLE));
    chk("rst_mid_trig", 9'(triggered), 9'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("single_rst_idle", 9'(state), 9'(S_IDLE));

    // Free-run: first accepted sample starts the capture.
    trig_mode = 2'd3;
    @(posedge clk); #1;
    chk("free_wait", 9'(state), 9'(S_WAIT));
    samp(12'd800, 12'd0);
    chk("free_first", 9'(state), 9'(S_CAP));
    repeat (479) samp(12'd800, 12'd0);
    chk("free_done", 9'(state), 9'(S_DONE));
    pulse_fs();
    chk("trig_free", 9'(triggered), 9'd0);
    chk("free_rewait", 9'(state), 9'(S_WAIT));
    pix(10'd160, 10'd379, 1'b1, GRN, "free_ch0");
    pix(10'd160, 10'd479, 1'b1, YEL, "free_ch1");
    pix_done();

    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain left=%0d want=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
